// File: rtl/skid_pkg.sv
// Shared state encoding and decode helpers for the skid_reg pipeline stage.
package skid_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY  = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

    // The unused code 2'd3 decodes as EMPTY: nothing presented, ready to accept.
    function automatic logic st_out_valid(input logic [ST_W-1:0] st);
        return (st == ST_BUSY) || (st == ST_FULL);
    endfunction

    function automatic logic st_in_ready(input logic [ST_W-1:0] st);
        return (st != ST_FULL);
    endfunction

endpackage

// File: rtl/skid_reg_en_reg.sv
// Clock-enabled data register with asynchronous active-high reset to a parameter value.
module en_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/skid_reg.sv
// Valid/ready pipeline register with a one-entry skid buffer; every output comes from a flop.
module skid_reg
    import skid_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= st_out_valid(w_state_nxt);
            r_in_ready  <= st_in_ready(w_state_nxt);
        end
    end

    // Next-state and data-register enables; flush overrides every handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire && !out_ready) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (!w_in_fire && w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_load_main),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_load_skid),
        .i_d  (in_data),
        .o_q  (w_skid_q)
    );

    assign out_data  = w_main_q;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomized bench for skid_reg against a two-slot FIFO reference model.
module tb_skid_reg;

    localparam int unsigned W = 7;
    localparam logic [W-1:0] RV = 7'h55;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] shown;
    logic         watch = 1'b0;
    int           forbidden = 0;

    skid_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: stage holds up to two beats in order; out_data shows the head, or the last head when empty.
    task automatic model_check();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready",  32'(in_ready),  32'(q.size() < 2));
        check("out_data",  32'(out_data),  32'(shown));
    endtask

    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        logic in_fire;
        logic out_fire;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        in_fire   = iv && (q.size() < 2);
        out_fire  = ordy && (q.size() > 0);
        if (watch && out_valid && out_ready &&
            (out_data == 7'h11 || out_data == 7'h22 || out_data == 7'h33))
            forbidden++;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(id);
        end
        if (q.size() > 0) shown = q[0];
        #1;
        model_check();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        shown = RV;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_check();
        check("reset_data", 32'(out_data), 32'(7'h55));

        // Asynchronous reset with a beat presented
        step(1'b1, 7'h0A, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        q.delete();
        shown = RV;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        check("async_rst_data",  32'(out_data), 32'(7'h55));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b0, 1'b0);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            check("stream_data",  32'(out_data), 32'(i));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        step(1'b0, 7'h00, 1'b1, 1'b0);

        // Stall into the skid slot, then recover
        step(1'b1, 7'h0A, 1'b1, 1'b0);
        step(1'b1, 7'h0B, 1'b0, 1'b0);
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_data",  32'(out_data), 32'(7'h0A));
        step(1'b0, 7'h00, 1'b1, 1'b0);
        check("recover_ready", 32'(in_ready), 32'd1);
        check("recover_data",  32'(out_data), 32'(7'h0B));
        step(1'b0, 7'h00, 1'b1, 1'b0);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Simultaneous accept and deliver
        step(1'b1, 7'h05, 1'b0, 1'b0);
        step(1'b1, 7'h0C, 1'b1, 1'b0);
        check("simul_data",  32'(out_data), 32'(7'h0C));
        check("simul_valid", 32'(out_valid), 32'd1);
        step(1'b0, 7'h00, 1'b1, 1'b0);

        // Flush from FULL with a beat offered on the flush cycle
        watch = 1'b1;
        step(1'b1, 7'h11, 1'b0, 1'b0);
        step(1'b1, 7'h22, 1'b0, 1'b0);
        check("pre_flush_ready", 32'(in_ready), 32'd0);
        step(1'b1, 7'h33, 1'b0, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_hold",  32'(out_data), 32'(7'h11));
        for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b1, 1'b0);
        step(1'b1, 7'h44, 1'b1, 1'b0);
        check("post_flush_data", 32'(out_data), 32'(7'h44));
        step(1'b0, 7'h00, 1'b1, 1'b0);
        check("flushed_never_fired", 32'(forbidden), 32'd0);
        watch = 1'b0;

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 128) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_reg.md
# skid_reg

Parametrised pipeline register with a valid/ready handshake and a one-entry skid buffer. It generalises the plain clock-enabled register to arbitrary width and reset value. It adds backpressure, a synchronous flush and full-throughput decoupling: no combinational path runs between the upstream and downstream sides. It sits between CPU pipeline stages and between bus masters and peripherals, wherever a stage must stall without dropping data.

## Interface
- WIDTH, 32: data width in bits, ≥1.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into both data registers on reset.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all held data.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  registered; stage can accept a beat.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  registered; beat presented downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  registered downstream payload.

## Operation
- Handshake rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A beat transfers on the rising edge where fire is 1.
- Storage:
  - main register drives out_data.
  - skid register holds the one overflow beat.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. in_fire → main<=in_data, go BUSY.
  - BUSY: out_valid=1, in_ready=1.
    - in_fire & out_fire → main<=in_data, stay BUSY.
    - in_fire & !out_ready → skid<=in_data, go FULL.
    - !in_fire & out_fire → go EMPTY.
    - Otherwise hold.
  - FULL: out_valid=1, in_ready=0. out_fire → main<=skid, go BUSY. Otherwise hold.
- Output decode: out_valid = (state!=EMPTY); in_ready = (state!=FULL). Both come from flops, not from in_valid/out_ready.
- flush:
  - Next state is EMPTY regardless of current state or handshakes.
  - A beat accepted on the flush cycle is discarded.
  - Data registers are not reloaded, so out_data keeps its last value while out_valid=0.
- Priority: rst > flush > handshake transitions.
- out_data with out_valid=0: holds main, never X after reset.
- Ordering: beats exit in acceptance order; none is duplicated or lost except by flush.

## Timing
- Reset values:
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_data=RESET_VAL, skid=RESET_VAL.
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N; the earliest downstream fire is edge N+1.
- Throughput: one beat per cycle when out_ready is held at 1.
- Backpressure: in_ready falls one cycle after the first stalled accept, which the skid register absorbs.
- Recovery: after FULL, the first out_fire re-raises in_ready at the next cycle.
- Reset mid-operation: asserting rst immediately (asynchronously) drives the reset values and discards held beats. Release is synchronous to clk via the existing reset synchroniser.
- flush takes effect at the next edge: out_valid=0, in_ready=1 after that edge.

## Structure
- Shared package skid_pkg:
  - State encoding localparams: ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - Unused code 2'd3 decodes to EMPTY.
- One natural sub-module: en_reg #(WIDTH, RESET_VAL), an async-reset clock-enabled register instantiated for main and skid.
  - main enable: load-from-input or load-from-skid, with a mux on D.
- Next-state logic, output decode and flush priority live in skid_reg.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 → out_valid=0, in_ready=1, out_data=RESET_VAL immediately, before the next clk edge. Release, idle 3 cycles → all three outputs unchanged.
- Streaming: out_ready=1, drive 0x1 through 0x8 on consecutive cycles → out_data shows 0x1 through 0x8 one cycle later, in_ready stays 1.
- Stall: in BUSY holding 0xA, drop out_ready while accepting 0xB → state FULL, in_ready=0, out_data=0xA. Raise out_ready → 0xA then 0xB delivered, in_ready=1 one cycle after 0xA leaves.
- Simultaneous: in BUSY, in_fire and out_fire on the same edge with 0xC → out_data=0xC, out_valid stays 1, no bubble.
- Flush: in FULL holding 0x11/0x22, pulse flush with in_valid=1 and in_data=0x33 → next cycle out_valid=0, in_ready=1. 0x11, 0x22 and 0x33 never appear on a downstream fire.
- Random valid/ready for 10k cycles with a WIDTH=7 instance → scoreboard order matches, no handshake loss.
